// File: rtl/seg_pkg.sv
// Seven-segment encoding shared by the BCD counter.
// Codes are active-low {dp,g,f,e,d,c,b,a} with the decimal point off.
package seg_pkg;

   localparam logic [3:0] BCD_MAX   = 4'd9;

   localparam logic [7:0] SEG_0     = 8'hC0;
   localparam logic [7:0] SEG_1     = 8'hF9;
   localparam logic [7:0] SEG_2     = 8'hA4;
   localparam logic [7:0] SEG_3     = 8'hB0;
   localparam logic [7:0] SEG_4     = 8'h99;
   localparam logic [7:0] SEG_5     = 8'h92;
   localparam logic [7:0] SEG_6     = 8'h82;
   localparam logic [7:0] SEG_7     = 8'hF8;
   localparam logic [7:0] SEG_8     = 8'h80;
   localparam logic [7:0] SEG_9     = 8'h90;
   localparam logic [7:0] SEG_BLANK = 8'hFF;

   // A nibble that is not a decimal digit is shown blank.
   function automatic logic [7:0] bcd2seg(input logic [3:0] v);
      logic [7:0] s;
      case (v)
         4'd0:    s = SEG_0;
         4'd1:    s = SEG_1;
         4'd2:    s = SEG_2;
         4'd3:    s = SEG_3;
         4'd4:    s = SEG_4;
         4'd5:    s = SEG_5;
         4'd6:    s = SEG_6;
         4'd7:    s = SEG_7;
         4'd8:    s = SEG_8;
         4'd9:    s = SEG_9;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade of the BCD counter. The decade moves only when the shared
// step is active and every lower decade is at its limit (cin). cout is
// combinational so a carry/borrow ripples through all decades in one edge.
module bcd_digit
   import seg_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       step,
   input  logic       up_dn,
   input  logic       cin,
   input  logic       clr,
   input  logic       load,
   input  logic [3:0] d,
   output logic [3:0] q,
   output logic       cout
);

   logic at_limit;

   assign at_limit = up_dn ? (q == BCD_MAX) : (q == 4'd0);
   assign cout     = cin & at_limit;

   // Decade register: clear beats load beats step; non-decimal loads become 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= 4'd0;
      end else if (clr) begin
         q <= 4'd0;
      end else if (load) begin
         q <= (d > BCD_MAX) ? 4'd0 : d;
      end else if (step && cin) begin
         if (up_dn) begin
            q <= at_limit ? 4'd0 : q + 4'd1;
         end else begin
            q <= at_limit ? BCD_MAX : q - 4'd1;
         end
      end
   end

endmodule

// File: rtl/seg_bcd_counter.sv
// Multi-digit BCD up/down counter with multiplexed seven-segment drive.
// Optional build macro SEG_BCD_COUNTER_ZERO_BLANK_EN blanks leading zeros
// on the display (digit 0 always shown); the bcd output is unaffected.
module seg_bcd_counter
   import seg_pkg::*;
#(
   parameter int TICK_DIV = 50_000_000,
   parameter int DIGITS   = 6,
   parameter int SCAN_DIV = 50_000
)
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  up_dn,
   input  logic                  clr,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  wrap,
   output logic [DIGITS-1:0]     seg_sel,
   output logic [7:0]            seg_data
);

   localparam int PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IDX_W  = (DIGITS > 1)   ? $clog2(DIGITS)   : 1;

   localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_DIV - 1);
   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);

   logic [PRE_W-1:0]  pre;
   logic              step;
   logic [DIGITS:0]   carry;
   logic [SCAN_W-1:0] scan_cnt;
   logic [IDX_W-1:0]  idx;
   logic [3:0]        cur_digit;
   logic              cur_blank;
   logic [DIGITS-1:0] blank_mask;
   logic [DIGITS-1:0] sel_next;

   assign step     = en && (pre == PRE_LAST);
   assign carry[0] = 1'b1;

   // Prescaler: clear/load restart the count period, en=0 freezes it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre <= '0;
      end else if (clr || load) begin
         pre <= '0;
      end else if (en) begin
         pre <= (pre == PRE_LAST) ? '0 : pre + PRE_W'(1);
      end
   end

   for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      bcd_digit u_digit (
         .clk   (clk),
         .rst_n (rst_n),
         .step  (step),
         .up_dn (up_dn),
         .cin   (carry[i]),
         .clr   (clr),
         .load  (load),
         .d     (load_val[4*i +: 4]),
         .q     (bcd[4*i +: 4]),
         .cout  (carry[i+1])
      );
   end

   // Wrap pulse: a carry out of the top decade on a real step only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrap <= 1'b0;
      end else begin
         wrap <= step && carry[DIGITS] && !clr && !load;
      end
   end

   // Scan timer and digit index, free-running independent of en.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_cnt <= '0;
         idx      <= '0;
      end else if (scan_cnt == SCAN_LAST) begin
         scan_cnt <= '0;
         idx      <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      end else begin
         scan_cnt <= scan_cnt + SCAN_W'(1);
      end
   end

`ifdef SEG_BCD_COUNTER_ZERO_BLANK_EN
   // blank_mask[i]: digit i and every digit above it are zero (never digit 0).
   always_comb begin
      blank_mask = '0;
      blank_mask[DIGITS-1] = (bcd[4*DIGITS-1 -: 4] == 4'd0);
      for (int i = DIGITS - 2; i >= 0; i--) begin
         blank_mask[i] = blank_mask[i+1] && (bcd[4*i +: 4] == 4'd0);
      end
      blank_mask[0] = 1'b0;
   end
`else
   // Every digit is shown, leading zeros included.
   always_comb begin
      blank_mask = '0;
   end
`endif

   // Select the digit under the scan index and its one-hot select pattern.
   always_comb begin
      cur_digit = 4'd0;
      cur_blank = 1'b0;
      sel_next  = '1;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx == IDX_W'(i)) begin
            cur_digit   = bcd[4*i +: 4];
            cur_blank   = blank_mask[i];
            sel_next[i] = 1'b0;
         end
      end
   end

   // Select and segment data registered together so they never disagree.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_sel  <= '1;
         seg_data <= SEG_BLANK;
      end else begin
         seg_sel  <= sel_next;
         seg_data <= cur_blank ? SEG_BLANK : bcd2seg(cur_digit);
      end
   end

endmodule

// File: tb/tb_seg_bcd_counter.sv
// Bench for seg_bcd_counter with TICK_DIV=4, DIGITS=3, SCAN_DIV=2.
module tb_seg_bcd_counter;

`ifdef SEG_BCD_COUNTER_ZERO_BLANK_EN
   localparam bit ZB = 1'b1;
`else
   localparam bit ZB = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic        en;
   logic        up_dn;
   logic        clr;
   logic        load;
   logic [11:0] load_val;
   logic [11:0] bcd;
   logic        wrap;
   logic [2:0]  seg_sel;
   logic [7:0]  seg_data;

   seg_bcd_counter #(.TICK_DIV(4), .DIGITS(3), .SCAN_DIV(2)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .up_dn    (up_dn),
      .clr      (clr),
      .load     (load),
      .load_val (load_val),
      .bcd      (bcd),
      .wrap     (wrap),
      .seg_sel  (seg_sel),
      .seg_data (seg_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [11:0] bcd;
      logic        wrap;
      logic [2:0]  sel;
      logic [7:0]  dat;
   } exp_t;

   typedef struct {
      logic        en;
      logic        up_dn;
      logic        clr;
      logic        load;
      logic [11:0] lv;
      int          n;
      logic [11:0] exp_bcd;
      int          exp_wraps;
   } vec_t;

   exp_t       sb_q[$];
   vec_t       tbl[19];
   logic [7:0] seg_tab[10];

   int checks   = 0;
   int failures = 0;
   int val_m, pre_m, scnt_m, idx_m;
   int seg_wraps;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic int pow10(input int i);
      return (i == 0) ? 1 : (i == 1) ? 10 : 100;
   endfunction

   function automatic logic [11:0] to_bcd(input int v);
      logic [11:0] r;
      r[3:0]  = 4'((v / 1) % 10);
      r[7:4]  = 4'((v / 10) % 10);
      r[11:8] = 4'((v / 100) % 10);
      return r;
   endfunction

   function automatic int from_load(input logic [11:0] lv);
      int s;
      s = 0;
      for (int i = 0; i < 3; i++) begin
         if (lv[4*i +: 4] <= 4'd9) s += int'(lv[4*i +: 4]) * pow10(i);
      end
      return s;
   endfunction

   task automatic reset_model();
      val_m  = 0;
      pre_m  = 0;
      scnt_m = 0;
      idx_m  = 0;
   endtask

   // Predict the post-edge outputs, queue them, clock once, then compare.
   task automatic cycle();
      exp_t e;
      int   dig;
      bit   blank;
      e.sel        = 3'b111;
      e.sel[idx_m] = 1'b0;
      dig          = (val_m / pow10(idx_m)) % 10;
      blank        = ZB && (idx_m != 0) && (val_m < pow10(idx_m));
      e.dat        = blank ? 8'hFF : seg_tab[dig];
      e.wrap       = 1'b0;
      if (clr) begin
         val_m = 0;
         pre_m = 0;
      end else if (load) begin
         val_m = from_load(load_val);
         pre_m = 0;
      end else if (en) begin
         if (pre_m == 3) begin
            pre_m = 0;
            if (up_dn) begin
               if (val_m == 999) begin val_m = 0; e.wrap = 1'b1; end
               else val_m = val_m + 1;
            end else begin
               if (val_m == 0) begin val_m = 999; e.wrap = 1'b1; end
               else val_m = val_m - 1;
            end
         end else begin
            pre_m = pre_m + 1;
         end
      end
      if (scnt_m == 1) begin
         scnt_m = 0;
         idx_m  = (idx_m == 2) ? 0 : idx_m + 1;
      end else begin
         scnt_m = scnt_m + 1;
      end
      e.bcd = to_bcd(val_m);
      sb_q.push_back(e);

      @(posedge clk);
      #1;
      if (wrap === 1'b1) seg_wraps++;
      if (sb_q.size() == 0) begin
         chk("sb_empty", 32'd0, 32'd1);
      end else begin
         e = sb_q.pop_front();
         chk("bcd",      32'(bcd),      32'(e.bcd));
         chk("wrap",     32'(wrap),     32'(e.wrap));
         chk("seg_sel",  32'(seg_sel),  32'(e.sel));
         chk("seg_data", 32'(seg_data), 32'(e.dat));
      end
   endtask

   task automatic set_in(input logic e_i, input logic u_i, input logic c_i,
                         input logic l_i, input logic [11:0] lv_i);
      en       = e_i;
      up_dn    = u_i;
      clr      = c_i;
      load     = l_i;
      load_val = lv_i;
   endtask

   initial begin
      int n_sel[3];
      logic [7:0] want;

      seg_tab[0] = 8'hC0; seg_tab[1] = 8'hF9; seg_tab[2] = 8'hA4;
      seg_tab[3] = 8'hB0; seg_tab[4] = 8'h99; seg_tab[5] = 8'h92;
      seg_tab[6] = 8'h82; seg_tab[7] = 8'hF8; seg_tab[8] = 8'h80;
      seg_tab[9] = 8'h90;

      //           en    up    clr   load  load_val n   exp_bcd wraps
      tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 12'h000, 40, 12'h010, 0};
      tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 12'h999,  1, 12'h999, 0};
      tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 12'h000,  4, 12'h000, 1};
      tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 12'h000,  6, 12'h000, 0};
      tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 12'h000,  1, 12'h000, 0};
      tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 12'h000,  4, 12'h999, 1};
      tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 12'h000,  4, 12'h998, 0};
      tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 12'h1F5,  1, 12'h105, 0};
      tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 12'h000,  3, 12'h105, 0};
      tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 12'h321,  1, 12'h321, 0};
      tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 12'h000,  2, 12'h321, 0};
      tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 10, 12'h321, 0};
      tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 12'h000,  1, 12'h321, 0};
      tbl[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 12'h000,  1, 12'h322, 0};
      tbl[14] = '{1'b1, 1'b1, 1'b1, 1'b1, 12'h555,  1, 12'h000, 0};
      tbl[15] = '{1'b0, 1'b1, 1'b0, 1'b1, 12'h007,  1, 12'h007, 0};
      tbl[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 12'h000,  8, 12'h007, 0};
      tbl[17] = '{1'b1, 1'b1, 1'b0, 1'b0, 12'h000,  3, 12'h007, 0};
      tbl[18] = '{1'b1, 1'b1, 1'b1, 1'b0, 12'h000,  1, 12'h000, 0};

      rst_n = 1'b0;
      set_in(1'b0, 1'b1, 1'b0, 1'b0, 12'h000);
      reset_model();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_bcd",      32'(bcd),      32'h000);
      chk("rst_wrap",     32'(wrap),     32'h0);
      chk("rst_seg_sel",  32'(seg_sel),  32'h7);
      chk("rst_seg_data", 32'(seg_data), 32'hFF);

      rst_n = 1'b1;
      for (int r = 0; r < 19; r++) begin
         set_in(tbl[r].en, tbl[r].up_dn, tbl[r].clr, tbl[r].load, tbl[r].lv);
         seg_wraps = 0;
         for (int c = 0; c < tbl[r].n; c++) cycle();
         chk($sformatf("row%0d_bcd", r), 32'(bcd), 32'(tbl[r].exp_bcd));
         chk($sformatf("row%0d_wraps", r), 32'(seg_wraps), 32'(tbl[r].exp_wraps));
      end

      // Scan pattern with a count of 007: each select held two cycles.
      set_in(1'b0, 1'b1, 1'b0, 1'b1, 12'h007);
      cycle();
      set_in(1'b0, 1'b1, 1'b0, 1'b0, 12'h000);
      cycle();
      for (int i = 0; i < 3; i++) n_sel[i] = 0;
      for (int c = 0; c < 6; c++) begin
         cycle();
         case (seg_sel)
            3'b110: begin n_sel[0]++; want = 8'hF8; end
            3'b101: begin n_sel[1]++; want = ZB ? 8'hFF : 8'hC0; end
            3'b011: begin n_sel[2]++; want = ZB ? 8'hFF : 8'hC0; end
            default: want = 8'h00;
         endcase
         chk("scan_data_for_sel", 32'(seg_data), 32'(want));
      end
      chk("scan_cnt_d0", 32'(n_sel[0]), 32'd2);
      chk("scan_cnt_d1", 32'(n_sel[1]), 32'd2);
      chk("scan_cnt_d2", 32'(n_sel[2]), 32'd2);

      // Asynchronous reset in the middle of counting.
      set_in(1'b1, 1'b1, 1'b0, 1'b0, 12'h000);
      repeat (5) cycle();
      rst_n = 1'b0;
      #2;
      chk("mid_rst_bcd",      32'(bcd),      32'h000);
      chk("mid_rst_wrap",     32'(wrap),     32'h0);
      chk("mid_rst_seg_sel",  32'(seg_sel),  32'h7);
      chk("mid_rst_seg_data", 32'(seg_data), 32'hFF);
      @(posedge clk);
      #1;
      reset_model();
      rst_n = 1'b1;
      repeat (4) cycle();
      chk("post_rst_first_step", 32'(bcd), 32'h001);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
